mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and main-memory handshake signals around the
// shared memory port. The arbiter takes the slave view; the requesters and
// the memory together take the master view.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // Fetch-stage side
    logic                    i_req_i;
    logic [ADDR_WIDTH-1:0]   i_addr_i;
    logic                    i_cancel_i;
    logic                    i_ready_o;
    logic [DATA_WIDTH-1:0]   i_rdata_o;
    // Memory-stage side
    logic                    d_req_i;
    logic                    d_we_i;
    logic [ADDR_WIDTH-1:0]   d_addr_i;
    logic [DATA_WIDTH-1:0]   d_wdata_i;
    logic [DATA_WIDTH/8-1:0] d_be_i;
    logic                    d_ready_o;
    logic [DATA_WIDTH-1:0]   d_rdata_o;
    // Main-memory port
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic                    mem_ack_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;
    // Hazard unit and status
    logic                    stall_f_o;
    logic                    stall_m_o;
    logic                    busy_o;

    modport slave (
        input  i_req_i, i_addr_i, i_cancel_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        input  mem_ack_i, mem_rdata_i,
        output i_ready_o, i_rdata_o, d_ready_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output stall_f_o, stall_m_o, busy_o
    );

    modport master (
        output i_req_i, i_addr_i, i_cancel_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
        output mem_ack_i, mem_rdata_i,
        input  i_ready_o, i_rdata_o, d_ready_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  stall_f_o, stall_m_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory port between instruction
// fetch and the data stage. Data wins ties (it belongs to the older
// instruction) unless fetch has been passed over STARVE_LIMIT times in a row.
// A fetch in flight can be cancelled by a mispredict redirect: the memory
// access still completes but its result is dropped.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                  state, state_next;
    logic                    grant_i, grant_d;
    logic                    i_elig, d_elig, starved;
    logic                    i_ready_q, d_ready_q;
    logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [DATA_WIDTH/8-1:0] lat_be;
    logic [CW-1:0]           starve_cnt;
    logic                    cancel_flag;

    // A requester whose ready pulse is out this cycle still shows req high;
    // it must not be granted again until its req has had a chance to drop.
    assign i_elig  = bus.i_req_i & ~i_ready_q;
    assign d_elig  = bus.d_req_i & ~d_ready_q;
    assign starved = (starve_cnt == LIMIT);

    // State register.
    // NOTE: sync reset and non-blocking assignment for every clocked state element.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and grant decision.
    // NOTE: defaults first so every path assigns every output -- no latches.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || !starved)) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_elig) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: if (bus.mem_ack_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port request and busy follow directly from the state.
    always_comb begin
        bus.mem_req_o = (state != IDLE);
        bus.busy_o    = (state != IDLE);
    end

    // Transaction latch, completion capture, starvation count and cancel flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            starve_cnt  <= '0;
            cancel_flag <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;

            if (grant_i) begin
                lat_we     <= 1'b0;
                lat_addr   <= bus.i_addr_i;
                lat_wdata  <= '0;
                lat_be     <= '1;
                starve_cnt <= '0;
            end

            if (grant_d) begin
                lat_we    <= bus.d_we_i;
                lat_addr  <= bus.d_addr_i;
                lat_wdata <= bus.d_wdata_i;
                lat_be    <= bus.d_be_i;
                if (!bus.i_req_i) starve_cnt <= '0;
                else if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == SERVE_I) begin
                if (bus.mem_ack_i) begin
                    // A cancel arriving in the ack cycle itself still counts.
                    if (!cancel_flag && !bus.i_cancel_i) begin
                        i_ready_q <= 1'b1;
                        i_rdata_q <= bus.mem_rdata_i;
                    end
                    cancel_flag <= 1'b0;
                end else if (bus.i_cancel_i) begin
                    cancel_flag <= 1'b1;
                end
            end

            if (state == SERVE_D && bus.mem_ack_i) begin
                d_ready_q <= 1'b1;
                if (!lat_we) d_rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.i_ready_o   = i_ready_q;
    assign bus.i_rdata_o   = i_rdata_q;
    assign bus.d_ready_o   = d_ready_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.mem_we_o    = lat_we;
    assign bus.mem_addr_o  = lat_addr;
    assign bus.mem_wdata_o = lat_wdata;
    assign bus.mem_be_o    = lat_be;
    assign bus.stall_f_o   = bus.i_req_i & ~i_ready_q;
    assign bus.stall_m_o   = bus.d_req_i & ~d_ready_q;
endmodule
